// File: rtl/lsu_mem_stage.sv
// Load/store unit: runs one AXI4-Lite-style read or write per request and holds
// the aligned/extended result until writeback accepts it.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [2:0]  mem_width,
   input  logic [31:0] addr,
   input  logic [31:0] wdata_in,
   input  logic [7:0]  wmask_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] rdata_out,
   output logic        err,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;

   state_t      state;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_width;
   logic [3:0]  req_wmask;
   logic [CW-1:0] tcnt;
   logic        misaligned;
   logic        stalled;
   logic        aw_ok;
   logic        w_ok;
   logic [31:0] rshift;
   logic [31:0] load_val;
   logic        unused_mask;

   assign unused_mask = ^wmask_in[7:4];
   assign in_ready    = (state == IDLE);
   assign araddr      = {req_addr[31:2], 2'b00};
   assign awaddr      = {req_addr[31:2], 2'b00};
   assign wdata       = req_wdata << {req_addr[1:0], 3'b000};
   assign wstrb       = req_wmask;
   assign rshift      = rdata >> {req_addr[1:0], 3'b000};
   assign aw_ok       = !awvalid || awready;
   assign w_ok        = !wvalid || wready;

   always_comb begin
      misaligned = 1'b0;
      case (mem_width[1:0])
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = (addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   always_comb begin
      load_val = rshift;
      case (req_width)
         3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
         3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_val = {24'b0, rshift[7:0]};
         3'b101:  load_val = {16'b0, rshift[15:0]};
         default: load_val = rshift;
      endcase
   end

   // A bus state is stalled when its completing handshake is absent this cycle.
   always_comb begin
      stalled = 1'b0;
      case (state)
         RD_ADDR: stalled = !arready;
         RD_DATA: stalled = !rvalid;
         WR:      stalled = !(aw_ok && w_ok);
         WR_RESP: stalled = !bvalid;
         default: stalled = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_addr  <= '0;
         req_wdata <= '0;
         req_width <= '0;
         req_wmask <= '0;
         tcnt      <= '0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         out_valid <= 1'b0;
         rdata_out <= '0;
         err       <= 1'b0;
      end else if (stalled && tcnt == T_LAST) begin
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         rdata_out <= '0;
         err       <= 1'b1;
         out_valid <= 1'b1;
         tcnt      <= '0;
         state     <= DONE;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               req_addr  <= addr;
               req_wdata <= wdata_in;
               req_width <= mem_width;
               req_wmask <= wmask_in[3:0];
               tcnt      <= '0;
               if ((mem_ren || mem_wen) && misaligned) begin
                  rdata_out <= '0;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (mem_wen) begin
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
                  state   <= WR;
               end else if (mem_ren) begin
                  arvalid <= 1'b1;
                  state   <= RD_ADDR;
               end else begin
                  rdata_out <= '0;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            RD_ADDR: if (arready) begin
               arvalid <= 1'b0;
               rready  <= 1'b1;
               tcnt    <= '0;
               state   <= RD_DATA;
            end else begin
               tcnt <= tcnt + CW'(1);
            end
            RD_DATA: if (rvalid) begin
               rready    <= 1'b0;
               rdata_out <= load_val;
               err       <= (rresp != 2'b00);
               out_valid <= 1'b1;
               tcnt      <= '0;
               state     <= DONE;
            end else begin
               tcnt <= tcnt + CW'(1);
            end
            WR: if (aw_ok && w_ok) begin
               awvalid <= 1'b0;
               wvalid  <= 1'b0;
               bready  <= 1'b1;
               tcnt    <= '0;
               state   <= WR_RESP;
            end else begin
               if (awready) awvalid <= 1'b0;
               if (wready) wvalid <= 1'b0;
               tcnt <= tcnt + CW'(1);
            end
            WR_RESP: if (bvalid) begin
               bready    <= 1'b0;
               rdata_out <= '0;
               err       <= (bresp != 2'b00);
               out_valid <= 1'b1;
               tcnt      <= '0;
               state     <= DONE;
            end else begin
               tcnt <= tcnt + CW'(1);
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
